// File: rtl/mux_seq_pkg.sv
// rtl/mux_seq_pkg.sv - shared constants and width helper for the channel mux sequencer
package mux_seq_pkg;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // Select width for n channels; a single-bit select is the floor.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mux_seq_if.sv
// rtl/mux_seq_if.sv - channel inputs, select controls and registered mux outputs
// master: drives data_in, sel, mode, ch_mask; observes data_out, cur_ch, out_valid, sel_err, wrap
// slave:  the sequencer side of the same bundle
interface mux_seq_if #(
    parameter int NUM_CH = 6,
    parameter int WIDTH  = 1
);
    import mux_seq_pkg::*;

    localparam int SEL_W = sel_width(NUM_CH);

    logic [NUM_CH*WIDTH-1:0] data_in;
    logic [SEL_W-1:0]        sel;
    logic                    mode;
    logic [NUM_CH-1:0]       ch_mask;
    logic [WIDTH-1:0]        data_out;
    logic [SEL_W-1:0]        cur_ch;
    logic                    out_valid;
    logic                    sel_err;
    logic                    wrap;

    modport master (
        output data_in, sel, mode, ch_mask,
        input  data_out, cur_ch, out_valid, sel_err, wrap
    );

    modport slave (
        input  data_in, sel, mode, ch_mask,
        output data_out, cur_ch, out_valid, sel_err, wrap
    );

endinterface

// File: rtl/mux_seq_next.sv
// rtl/mux_seq_next.sv - circular priority search for the next enabled channel
// in:  ptr (current channel), ch_mask (enabled channels)
// out: next_ch (first enabled channel above ptr, circularly), wrapped (next_ch <= ptr), any_en
module mux_seq_next
    import mux_seq_pkg::*;
#(
    parameter int NUM_CH = 6,
    parameter int SEL_W  = sel_width(NUM_CH)
) (
    input  logic [SEL_W-1:0]  ptr,
    input  logic [NUM_CH-1:0] ch_mask,
    output logic [SEL_W-1:0]  next_ch,
    output logic              wrapped,
    output logic              any_en
);

    logic found;
    int   idx;

    // Offsets 1..NUM_CH cover every channel once, ending back at ptr itself,
    // so a lone enabled channel selects itself and reports a wrap.
    always_comb begin
        next_ch = ptr;
        found   = 1'b0;
        idx     = 0;
        any_en  = |ch_mask;
        for (int i = 1; i <= NUM_CH; i++) begin
            idx = int'(ptr) + i;
            if (idx >= NUM_CH) begin
                idx = idx - NUM_CH;
            end
            if (!found && ch_mask[idx]) begin
                found   = 1'b1;
                next_ch = SEL_W'(idx);
            end
        end
        wrapped = any_en && (next_ch <= ptr);
    end

endmodule

// File: rtl/mux_seq.sv
// rtl/mux_seq.sv - registered channel mux with manual select and masked round-robin scan
// clk: rising-edge clock; rst: synchronous active-high reset
// bus (slave): data_in/sel/mode/ch_mask in; data_out/cur_ch/out_valid/sel_err/wrap out
module mux_seq
    import mux_seq_pkg::*;
#(
    parameter int NUM_CH = 6,
    parameter int WIDTH  = 1,
    parameter int DWELL  = 10
) (
    input  logic     clk,
    input  logic     rst,
    mux_seq_if.slave bus
);

    localparam int SEL_W  = sel_width(NUM_CH);
    localparam int DCNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DWELL - 1);

    logic [SEL_W-1:0]  ptr;
    logic [SEL_W-1:0]  next_ch;
    logic [DCNT_W-1:0] dcnt;
    logic              wrapped;
    logic              any_en;
    logic              sel_ok;
    logic              ptr_en;
    logic [WIDTH-1:0]  sel_data;
    logic [WIDTH-1:0]  ptr_data;

    // Out-of-range selects must not alias, so the slice is only used when in range.
    assign sel_ok   = int'(bus.sel) < NUM_CH;
    assign sel_data = sel_ok ? bus.data_in[int'(bus.sel)*WIDTH +: WIDTH] : '0;
    assign ptr_data = bus.data_in[int'(ptr)*WIDTH +: WIDTH];
    assign ptr_en   = bus.ch_mask[ptr];

    mux_seq_next #(
        .NUM_CH (NUM_CH),
        .SEL_W  (SEL_W)
    ) u_next (
        .ptr     (ptr),
        .ch_mask (bus.ch_mask),
        .next_ch (next_ch),
        .wrapped (wrapped),
        .any_en  (any_en)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr           <= '0;
            dcnt          <= '0;
            bus.data_out  <= '0;
            bus.cur_ch    <= '0;
            bus.out_valid <= 1'b0;
            bus.sel_err   <= 1'b0;
            bus.wrap      <= 1'b0;
        end else if (bus.mode == MODE_MANUAL) begin
            dcnt     <= '0;
            bus.wrap <= 1'b0;
            if (sel_ok) begin
                bus.data_out  <= sel_data;
                bus.cur_ch    <= bus.sel;
                bus.out_valid <= 1'b1;
                bus.sel_err   <= 1'b0;
                ptr           <= bus.sel;
            end else begin
                bus.out_valid <= 1'b0;
                bus.sel_err   <= 1'b1;
            end
        end else begin
            bus.sel_err <= 1'b0;
            if (!any_en) begin
                bus.out_valid <= 1'b0;
                dcnt          <= '0;
                bus.wrap      <= 1'b0;
            end else begin
                // A channel disabled mid-dwell still delivers this one sample,
                // then the pointer moves on exactly as at dwell expiry.
                bus.data_out  <= ptr_data;
                bus.cur_ch    <= ptr;
                bus.out_valid <= 1'b1;
                if (!ptr_en || dcnt == DCNT_LAST) begin
                    ptr      <= next_ch;
                    dcnt     <= '0;
                    bus.wrap <= wrapped;
                end else begin
                    dcnt     <= dcnt + DCNT_W'(1);
                    bus.wrap <= 1'b0;
                end
            end
        end
    end

endmodule
